// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with 4-word lines refilled over a 128-bit handshake.
// Optional hit/miss counters when ICACHE_PERF_EN is defined.
module icache_direct_mapped #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [31:0]         proc_wdata,
    output logic                proc_stall,
    output logic [31:0]         proc_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [127:0]        mem_wdata,
    input  logic                mem_ready,
    input  logic [127:0]        mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]         perf_hit,
    output logic [31:0]         perf_miss
`endif
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_mem_read;
    logic [ADDR_W-3:0]  r_mem_addr;
    logic               r_valid [NUM_BLOCKS];
    logic [TAG_W-1:0]   r_tag   [NUM_BLOCKS];
    logic [127:0]       r_data  [NUM_BLOCKS];

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_req;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill;
    logic               w_unused_ok;

    assign w_idx       = proc_addr[IDX_W+1:2];
    assign w_tag       = proc_addr[ADDR_W-1:IDX_W+2];
    assign w_fill_idx  = r_mem_addr[IDX_W-1:0];
    assign w_fill_tag  = r_mem_addr[ADDR_W-3:IDX_W];
    // A write request on the read-only port is treated as no request at all.
    assign w_req       = proc_read & ~proc_write;
    assign w_hit       = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss      = (r_state == S_IDLE) & w_req & ~w_hit;
    assign w_fill      = (r_state == S_FETCH) & mem_ready;
    assign w_unused_ok = ^proc_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_miss)    w_state_next = S_FETCH;
            S_FETCH: if (mem_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        proc_stall = w_req & ((r_state == S_FETCH) | ~w_hit);
        proc_rdata = r_data[w_idx][{proc_addr[1:0], 5'b0} +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
        end else if (w_miss) begin
            r_mem_read <= 1'b1;
            r_mem_addr <= proc_addr[ADDR_W-1:2];
        end else if (w_fill) begin
            r_mem_read <= 1'b0;
        end
    end

    // Refill uses the latched line address so a dropped proc_read still installs the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BLOCKS; i++) r_valid[i] <= 1'b0;
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill && !rst) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_rdata;
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_addr  = r_mem_addr;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

`ifdef ICACHE_PERF_EN
    logic        r_fill_done;
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    // r_fill_done marks the post-refill hit cycle, which is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_done <= 1'b0;
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else begin
            r_fill_done <= w_fill;
            if (w_hit && r_state == S_IDLE && !r_fill_done && r_perf_hit != 32'hFFFF_FFFF)
                r_perf_hit <= r_perf_hit + 32'd1;
            if (w_miss && r_perf_miss != 32'hFFFF_FFFF)
                r_perf_miss <= r_perf_miss + 32'd1;
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed testbench for icache_direct_mapped: cold miss, reuse, conflict, reset mid-refill, ignored inputs.
// Define ICACHE_PERF_EN to also check the hit/miss counters.
module tb_icache_direct_mapped;
    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0]  perf_hit;
    logic [31:0]  perf_miss;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0001,
                            D2 = 32'h3333_0002, D3 = 32'h4444_0003;
    localparam logic [31:0] E0 = 32'hAAAA_0000, E1 = 32'hBBBB_0001,
                            E2 = 32'hCCCC_0002, E3 = 32'hDDDD_0003;
    localparam logic [127:0] LINE_D = {D3, D2, D1, D0};
    localparam logic [127:0] LINE_E = {E3, E2, E1, E0};
    localparam logic [127:0] LINE_F = {4{32'hDEAD_BEEF}};

    icache_direct_mapped #(.NUM_BLOCKS(8), .ADDR_W(30)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit   (perf_hit),
        .perf_miss  (perf_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [127:0] line);
        mem_rdata = line;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic read_at(input logic [29:0] a);
        proc_read = 1'b1;
        proc_addr = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0;
        proc_wdata = 32'h5A5A_5A5A; mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_addr", {4'b0, mem_addr}, 32'd0);
        check("rst_stall_idle", {31'b0, proc_stall}, 32'd0);
        check("mem_write_tied", {31'b0, mem_write}, 32'd0);

        // T1: cold miss
        read_at(30'h10);
        check("t1_stall_same_cycle", {31'b0, proc_stall}, 32'd1);
        tick();
        check("t1_mem_read", {31'b0, mem_read}, 32'd1);
        check("t1_mem_addr", {4'b0, mem_addr}, 32'h4);
        for (int i = 0; i < 4; i++) tick();
        check("t1_stall_fetch", {31'b0, proc_stall}, 32'd1);
        check("t1_mem_read_held", {31'b0, mem_read}, 32'd1);
        check("t1_mem_addr_held", {4'b0, mem_addr}, 32'h4);
        refill(LINE_D);
        check("t1_stall_after_fill", {31'b0, proc_stall}, 32'd0);
        check("t1_rdata_d0", proc_rdata, D0);
        check("t1_mem_read_drop", {31'b0, mem_read}, 32'd0);
        tick();

        // T2: line reuse, no stalls
        read_at(30'h11);
        check("t2_stall_11", {31'b0, proc_stall}, 32'd0);
        check("t2_rdata_d1", proc_rdata, D1);
        tick();
        read_at(30'h12);
        check("t2_stall_12", {31'b0, proc_stall}, 32'd0);
        check("t2_rdata_d2", proc_rdata, D2);
        tick();
        read_at(30'h13);
        check("t2_stall_13", {31'b0, proc_stall}, 32'd0);
        check("t2_rdata_d3", proc_rdata, D3);
        tick();
        proc_read = 1'b0;
        #1;
`ifdef ICACHE_PERF_EN
        check("t6_perf_miss", perf_miss, 32'd1);
        check("t6_perf_hit", perf_hit, 32'd3);
`endif

        // T3: conflict on index 4
        read_at(30'h30);
        check("t3_stall_conflict", {31'b0, proc_stall}, 32'd1);
        tick();
        check("t3_mem_addr_30", {4'b0, mem_addr}, 32'hC);
        tick();
        refill(LINE_E);
        check("t3_rdata_e0", proc_rdata, E0);
        tick();
        read_at(30'h10);
        check("t3_remiss_stall", {31'b0, proc_stall}, 32'd1);
        tick();
        check("t3_remiss_addr", {4'b0, mem_addr}, 32'h4);
        refill(LINE_D);
        check("t3_rdata_d0", proc_rdata, D0);
        tick();

        // T4: reset during refill, stale mem_ready afterwards
        read_at(30'h30);
        tick();
        check("t4_in_fetch", {31'b0, mem_read}, 32'd1);
        rst = 1'b1;
        proc_read = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("t4_mem_read_after_rst", {31'b0, mem_read}, 32'd0);
        tick();
        refill(LINE_E);
        check("t4_stale_no_mem_read", {31'b0, mem_read}, 32'd0);
        read_at(30'h30);
        check("t4_30_not_installed", {31'b0, proc_stall}, 32'd1);
        proc_addr = 30'h10;
        #1;
        check("t4_10_misses", {31'b0, proc_stall}, 32'd1);
        tick();
        check("t4_refetch_addr", {4'b0, mem_addr}, 32'h4);
        refill(LINE_D);
        check("t4_rdata_d0", proc_rdata, D0);
        tick();

        // T5: spurious mem_ready in IDLE, proc_write ignored
        proc_read = 1'b0;
        refill(LINE_F);
        check("t5_spurious_mem_read", {31'b0, mem_read}, 32'd0);
        read_at(30'h10);
        check("t5_hit_stall", {31'b0, proc_stall}, 32'd0);
        check("t5_contents_kept", proc_rdata, D0);
        tick();
        proc_read = 1'b1; proc_write = 1'b1; proc_addr = 30'h30;
        #1;
        check("t5_write_no_stall", {31'b0, proc_stall}, 32'd0);
        tick();
        check("t5_write_no_mem_read", {31'b0, mem_read}, 32'd0);
        proc_write = 1'b0; proc_read = 1'b0;
        #1;

`ifdef ICACHE_PERF_EN
        // T6: saturation of perf_hit
        force dut.r_perf_hit = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_hit;
        read_at(30'h10);
        tick();
        proc_read = 1'b0;
        #1;
        check("t6_perf_hit_sat", perf_hit, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
